alu_issue: RTL

ALU_ISSUE -- requirements
Module: alu_issue

---
 rtl/alu_issue.sv | 109 ++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// alu_issue: decodes an instruction into ALU operands and buffers results in a 2-entry FIFO
module alu_issue #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic [4:0]            shamt,
  input  logic [15:0]           imm,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic [2:0]            alu_op,
  output logic                  illegal,
  output logic [1:0]            count
);
  localparam int EW = 2 * DATA_WIDTH + 4;
  localparam logic [1:0] FULL = 2'(DEPTH);
  logic [DATA_WIDTH-1:0] dec_a, dec_b, sext, zext;
  logic [2:0] dec_op;
  logic dec_ill, push, pop;
  logic [EW-1:0] mem_q [2];
  logic [EW-1:0] mem_d [2];
  logic wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  assign sext = {{(DATA_WIDTH-16){imm[15]}}, imm};
  assign zext = {{(DATA_WIDTH-16){1'b0}}, imm};
  always_comb begin
    dec_a = rs_data;
    dec_b = rt_data;
    dec_op = 3'b010;
    dec_ill = 1'b0;
    case (opcode)
      6'b000000:
        case (funct)
          6'b100001: dec_op = 3'b010;
          6'b100011: dec_op = 3'b110;
          6'b100100: dec_op = 3'b000;
          6'b100101: dec_op = 3'b001;
          6'b101010: dec_op = 3'b111;
          6'b101011: dec_op = 3'b011;
          6'b000000: begin
            dec_op = 3'b101;
            dec_a = {{(DATA_WIDTH-5){1'b0}}, shamt};
          end
          default: begin
            dec_a = '0;
            dec_b = '0;
            dec_ill = 1'b1;
          end
        endcase
      6'b001001: dec_b = sext;
      6'b001010: begin dec_op = 3'b111; dec_b = sext; end
      6'b001011: begin dec_op = 3'b011; dec_b = sext; end
      6'b001100: begin dec_op = 3'b000; dec_b = zext; end
      6'b001101: begin dec_op = 3'b001; dec_b = zext; end
      6'b001111: begin dec_op = 3'b100; dec_a = '0; dec_b = zext; end
      6'b100011, 6'b101011: dec_b = sext;
      6'b000100, 6'b000101: dec_op = 3'b110;
      default: begin
        dec_a = '0;
        dec_b = '0;
        dec_ill = 1'b1;
      end
    endcase
  end
  assign in_ready = count_q != FULL;
  assign out_valid = count_q != 2'd0;
  assign count = count_q;
  assign push = in_valid & in_ready & ~flush;
  assign pop = out_valid & out_ready;
  assign {alu_a, alu_b, alu_op, illegal} = out_valid ? mem_q[rd_ptr_q] : '0;
  always_comb begin
    mem_d = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d = count_q + 2'(push) - 2'(pop);
    if (push) begin
      mem_d[wr_ptr_q] = {dec_a, dec_b, dec_op, dec_ill};
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    if (flush) begin
      count_d = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      count_q <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
endmodule
